// File: rtl/pipelined_addsub.sv
// Slice-pipelined adder/subtractor: stage k adds one WIDTH/STAGES-bit slice and forwards the carry.
// Define PIPELINED_ADDSUB_SAT_EN to clamp the result to the signed limit on overflow.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SL = WIDTH / STAGES;

  logic en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SL;       // lowest bit of this stage's slice
    localparam int unsigned RW = WIDTH - LO;   // operand bits not yet consumed

    logic [RW-1:0]    a_in, b_in;
    logic             c_in, v_in;
    logic [SL:0]      slice;
    logic [LO+SL-1:0] r_d;
    logic             c_q, v_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_in = a;
        b_in = sub ? ~b : b;
        c_in = cin;
        v_in = in_valid;
        r_d  = slice[SL-1:0];
      end
    end else begin : g_src
      always_comb begin
        a_in = g_stage[k-1].g_fwd.a_q;
        b_in = g_stage[k-1].g_fwd.b_q;
        c_in = g_stage[k-1].c_q;
        v_in = g_stage[k-1].v_q;
        r_d  = {slice[SL-1:0], g_stage[k-1].g_fwd.r_q};
      end
    end

    always_comb begin
      slice = {1'b0, a_in[SL-1:0]} + {1'b0, b_in[SL-1:0]} + (SL+1)'(c_in);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= slice[SL];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SL-1:0] a_q, b_q;
      logic [LO+SL-1:0] r_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
        end else if (en) begin
          a_q <= a_in[RW-1:SL];
          b_q <= b_in[RW-1:SL];
          r_q <= r_d;
        end
      end
    end else begin : g_out
      logic             ovf_d, ovf_q;
      logic [WIDTH-1:0] sum_d, sum_q;

      // Carry into the MSB is recovered from the MSB's operand and sum bits.
      always_comb begin
        ovf_d = a_in[SL-1] ^ b_in[SL-1] ^ slice[SL-1] ^ slice[SL];
        sum_d = r_d;
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (ovf_d) begin
          sum_d = slice[SL] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q <= '0;
          ovf_q <= 1'b0;
        end else if (en) begin
          sum_q <= sum_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = g_stage[STAGES-1].v_q;
    en        = !out_valid || out_ready;
    in_ready  = en;
    sum       = g_stage[STAGES-1].g_out.sum_q;
    cout      = g_stage[STAGES-1].c_q;
    ovf       = g_stage[STAGES-1].g_out.ovf_q;
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomized bench for pipelined_addsub (WIDTH=16, STAGES=4) against an integer-arithmetic model.
module tb_pipelined_addsub;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           t;
  } exp_t;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           n_out = 0;
  exp_t         q[$];
  exp_t         exp_in;
  bit           lat_chk = 0;
  bit           accepted;
  bit           stall_prev = 0;
  logic [W-1:0] sum_prev;
  logic         cout_prev, ovf_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t e;
    int   xv, yv, full, sx, sy, st;
    xv   = int'(x);
    yv   = s ? (65535 - int'(y)) : int'(y);
    full = xv + yv + int'(ci);
    e.cout = (full >= 65536);
    e.sum  = full[15:0];
    sx = (xv >= 32768) ? xv - 65536 : xv;
    sy = (yv >= 32768) ? yv - 65536 : yv;
    st = sx + sy + int'(ci);
    e.ovf = (st > 32767) || (st < -32768);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (e.ovf) e.sum = (st > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.t = 0;
    return e;
  endfunction

  task automatic set_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    a = x; b = y; cin = ci; sub = s;
    exp_in = model(x, y, ci, s);
  endtask

  // One clock cycle: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    check("in_ready", in_ready, !out_valid || out_ready);
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, sum_prev);
      check("hold_cout", cout, cout_prev);
      check("hold_ovf", ovf, ovf_prev);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", {31'b0, out_valid}, 0);
      end else begin
        e = q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
        if (lat_chk) check("latency", cyc - e.t, 4);
        n_out++;
      end
    end
    stall_prev = out_valid && !out_ready;
    sum_prev = sum; cout_prev = cout; ovf_prev = ovf;
    accepted = in_valid && in_ready;
    if (accepted) begin
      e = exp_in;
      e.t = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    a = x; b = y; cin = ci; sub = s;
    exp_in.sum = es; exp_in.cout = ec; exp_in.ovf = eo;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit pattern);
    for (int c = 0; c < 60 && q.size() != 0; c++) begin
      if (pattern) out_ready = (c % 4 == 0) || (c % 4 == 3);
      else out_ready = 1'b1;
      step();
    end
    check("drained", q.size(), 0);
  endtask

  logic [W-1:0] pos_ovf_sum, neg_ovf_sum;
  int           base, idx;

  initial begin
`ifdef PIPELINED_ADDSUB_SAT_EN
    pos_ovf_sum = 16'h7FFF;
    neg_ovf_sum = 16'h8000;
`else
    pos_ovf_sum = 16'h8000;
    neg_ovf_sum = 16'h7FFF;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_in_ready", in_ready, 1);

    // Directed vectors with continuous out_ready, exact latency checked.
    out_ready = 1'b1;
    lat_chk = 1;
    directed(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, pos_ovf_sum, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b1, 1'b1, neg_ovf_sum, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check("directed_done", q.size(), 0);

    // Ten back-to-back additions under a 1,0,0,1 out_ready pattern.
    lat_chk = 0;
    base = n_out;
    idx = 0;
    in_valid = 1'b1;
    set_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 100 && idx < 10; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      step();
      if (accepted) begin
        idx++;
        set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      end
    end
    in_valid = 1'b0;
    check("stream_accepted", idx, 10);
    drain(1);
    check("stream_delivered", n_out - base, 10);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if (c % 23 == 0) set_op(16'h7FFF - 16'($urandom_range(0, 3)), 16'($urandom_range(1, 8)), 1'b0, 1'b0);
      if (c % 29 == 0) set_op(16'h8000 + 16'($urandom_range(0, 3)), 16'($urandom_range(4, 9)), 1'b1, 1'b1);
      step();
    end
    in_valid = 1'b0;
    drain(0);

    // Three operations in flight, the oldest stalled at the output, then reset.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && !out_valid; c++) step();
    check("inflight_visible", out_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_in_ready", in_ready, 1);
    q.delete();
    stall_prev = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    lat_chk = 1;
    base = n_out;
    in_valid = 1'b1;
    set_op(16'h4321, 16'h1111, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("post_rst_results", n_out - base, 1);
    check("post_rst_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 4.
REQ-002 Parameter STAGES, default 4, number of pipeline stages, each adding one WIDTH/STAGES-bit slice; WIDTH SHALL be divisible by STAGES, and STAGES >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry/borrow-in (add: carry in; sub: added to ~b, so set 1 for a plain A-B).
REQ-010 sub  input  1  0 = A+B+cin, 1 = A+~B+cin.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of the MSB (unsigned carry; for sub, 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 Transfer occurs on a rising edge when valid and ready are both high, at the input and the output independently.
REQ-017 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally; when en is low every stage holds its contents.
REQ-018 Stage k (0..STAGES-1) adds slice k of a and of the effective B (b or ~b) plus the carry from stage k-1 (cin for k=0), registers slice sum and carry, and delays the upper, unconsumed operand slices unchanged.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid under continuous out_ready; throughput is one operation per cycle.
REQ-020 Each stage carries a valid bit; bubbles (in_valid low while en) propagate as invalid and SHALL NOT raise out_valid.
REQ-021 Results SHALL leave in input order with no loss or duplication under any out_ready pattern.
REQ-022 sum, cout, ovf SHALL be stable while out_valid && !out_ready.
REQ-023 ovf = carry into MSB XOR carry out of MSB; cout = carry out of MSB; arithmetic is modulo 2^WIDTH.
REQ-024 STAGES=1 SHALL degenerate to one registered full-width adder with 1-cycle latency.

Reset
REQ-025 While rst is high: all stage valid bits, out_valid, sum, cout and ovf SHALL be 0, asynchronously.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; the first input transfer after rst deasserts produces the first output.
REQ-027 in_ready SHALL be 1 during and immediately after reset (follows from out_valid=0).

Configuration
REQ-028 Macro PIPELINED_ADDSUB_SAT_EN: when defined, on ovf=1 sum SHALL be clamped to the signed limit (0x7FFF for positive overflow, 0x8000 for negative overflow at WIDTH=16); cout and ovf are reported unchanged.
REQ-029 Without PIPELINED_ADDSUB_SAT_EN, sum SHALL be the wrapped modulo result; no clamp logic SHALL be present.

Verification (WIDTH=16, STAGES=4)
REQ-030 After reset, a=0x1234, b=0x0FCD, sub=0, cin=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=0x2201, cout=0, ovf=0.
REQ-031 a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all slices).
REQ-032 a=0x7FFF, b=0x0001, sub=0, cin=0 -> ovf=1; sum=0x8000 without the macro, 0x7FFF with PIPELINED_ADDSUB_SAT_EN.
REQ-033 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1, cin=1 -> ovf=1, sum=0x7FFF (no macro) / 0x8000 (macro).
REQ-034 Stream 10 back-to-back additions while out_ready toggles 1,0,0,1,... -> in_ready tracks en, all 10 results are delivered in order with none lost, and sum holds stable during stalls.
REQ-035 Assert rst for one cycle with 3 operations in flight -> out_valid=0 immediately, none of the 3 results appear, and the next operation completes with 4-cycle latency.
